// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the two-master memory arbiter:
//               default bus widths, master id constants and the FSM state
//               encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int unsigned c_ADDR_W_DEFAULT = 32;
  localparam int unsigned c_DATA_W_DEFAULT = 32;

  // Master identifiers; also the value held in the grant-id register.
  typedef logic master_id_t;
  localparam master_id_t c_M0 = 1'b0;  // instruction fetch
  localparam master_id_t c_M1 = 1'b1;  // load/store

  // Arbiter FSM: one transaction in flight at a time.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_if
// Description : Request/response memory port. The "master" modport is the
//               side that issues requests; the "slave" modport accepts them.
// Ports       : req_valid/req_ready  request handshake
//               addr/wen/wdata/wmask request payload (wmask = DATA_W/8 bits)
//               resp_valid/resp_ready response handshake, rdata payload
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEFAULT,
  parameter int DATA_W = c_DATA_W_DEFAULT
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     addr;
  logic                  wen;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req_valid, addr, wen, wdata, wmask, resp_ready,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask, resp_ready,
    output req_ready, resp_valid, rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_arb_arb_2way.sv
`default_nettype none
// ============================================================================
// Module      : arb_2way
// Description : Two-requester grant logic. A lone requester always wins;
//               on a tie the pointer decides.
// Ports       : i_valid[1:0]  request valids (bit 1 = m1, bit 0 = m0)
//               i_prefer_m1   tie-break pointer (1 = m1 wins a tie)
//               o_grant[1:0]  one-hot grant, all-zero when nothing requests
// Revision    : 1.0 - initial release
// ============================================================================
module arb_2way (
  input  wire logic [1:0] i_valid,
  input  wire logic       i_prefer_m1,
  output logic      [1:0] o_grant
);

  assign o_grant[1] = i_valid[1] & (~i_valid[0] |  i_prefer_m1);
  assign o_grant[0] = i_valid[0] & (~i_valid[1] | ~i_prefer_m1);

endmodule
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Arbitrates two masters (m0 = IFU, m1 = LSU) onto a single
//               memory port, one transaction outstanding at a time.
//               IDLE grants combinationally and latches the winner's
//               request, REQ replays it to memory from registers, RESP
//               routes the memory response back to the granted master.
// Ports       : clk  clock, all state on rising edge
//               rst  asynchronous active-low reset
//               m0   master 0 port (slave modport)
//               m1   master 1 port (slave modport)
//               s    memory-side port (master modport)
// Config      : MEM_ARB_RR_EN defined   -> round-robin on simultaneous
//                                          requests
//               MEM_ARB_RR_EN undefined -> fixed priority, m1 wins
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W_DEFAULT,
  parameter int DATA_W = c_DATA_W_DEFAULT
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mem_arb_if.slave   m0,
  mem_arb_if.slave   m1,
  mem_arb_if.master  s
);

  localparam int c_MASK_W = DATA_W / 8;

  state_e              r_state;
  state_e              w_state_nxt;
  master_id_t          r_gid;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_MASK_W-1:0] r_wmask;

  logic [1:0]          w_grant;
  logic                w_prefer_m1;
  logic                w_accept;
  master_id_t          w_win_id;

  // --------------------------------------------------------------------------
  // Tie-break pointer
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
  logic r_prefer_m1;

  // After m0 is served m1 is preferred next, and vice versa.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prefer_m1 <= 1'b1;
    end else if (w_accept) begin
      r_prefer_m1 <= (w_win_id == c_M0);
    end
  end

  assign w_prefer_m1 = r_prefer_m1;
`else
  assign w_prefer_m1 = 1'b1;
`endif

  arb_2way u_arb (
    .i_valid     ({m1.req_valid, m0.req_valid}),
    .i_prefer_m1 (w_prefer_m1),
    .o_grant     (w_grant)
  );

  assign w_win_id = w_grant[1] ? c_M1 : c_M0;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Latched request and grant id
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gid   <= c_M0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_gid   <= w_win_id;
      r_addr  <= (w_win_id == c_M1) ? m1.addr  : m0.addr;
      r_wen   <= (w_win_id == c_M1) ? m1.wen   : m0.wen;
      r_wdata <= (w_win_id == c_M1) ? m1.wdata : m0.wdata;
      r_wmask <= (w_win_id == c_M1) ? m1.wmask : m0.wmask;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    m0.req_ready  = 1'b0;
    m1.req_ready  = 1'b0;
    m0.resp_valid = 1'b0;
    m1.resp_valid = 1'b0;
    m0.rdata      = '0;
    m1.rdata      = '0;
    s.req_valid   = 1'b0;
    s.addr        = '0;
    s.wen         = 1'b0;
    s.wdata       = '0;
    s.wmask       = '0;
    s.resp_ready  = 1'b0;

    case (r_state)
      IDLE: begin
        // The grant is purely combinational, so it is qualified with the
        // (active-low) reset to keep req_ready low while reset is held.
        m0.req_ready = w_grant[0] & rst;
        m1.req_ready = w_grant[1] & rst;
        if (|w_grant) begin
          w_accept    = 1'b1;
          w_state_nxt = REQ;
        end
      end

      REQ: begin
        s.req_valid = 1'b1;
        s.addr      = r_addr;
        s.wen       = r_wen;
        s.wdata     = r_wdata;
        s.wmask     = r_wmask;
        if (s.req_ready) begin
          w_state_nxt = RESP;
        end
      end

      RESP: begin
        if (r_gid == c_M1) begin
          m1.resp_valid = s.resp_valid;
          m1.rdata      = s.rdata;
          s.resp_ready  = m1.resp_ready;
        end else begin
          m0.resp_valid = s.resp_valid;
          m0.rdata      = s.rdata;
          s.resp_ready  = m0.resp_ready;
        end
        if (s.resp_valid && s.resp_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
